// File: rtl/conv_window5x5.sv
// Sliding 5x5 pixel window fed by a four-row line buffer. Tracks the raster
// position and flags windows lying fully inside the image.
module conv_window5x5 #(
  parameter int COLS      = 32,
  parameter int ROWS      = 32,
  parameter int BIT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [BIT_WIDTH-1:0]         px_in,
  input  logic [BIT_WIDTH-1:0]         tap0,
  input  logic [BIT_WIDTH-1:0]         tap1,
  input  logic [BIT_WIDTH-1:0]         tap2,
  input  logic [BIT_WIDTH-1:0]         tap3,
  output logic [25*BIT_WIDTH-1:0]      win,
  output logic                         win_valid,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic [$clog2(COLS)-1:0]      out_col,
  output logic                         frame_done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [25*BIT_WIDTH-1:0] win_q, win_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [RW-1:0]           out_row_q, out_row_d;
  logic [CW-1:0]           out_col_q, out_col_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    last_col_s, last_row_s;

  assign last_col_s = (col_q == CW'(COLS - 1));
  assign last_row_s = (row_q == RW'(ROWS - 1));

  // Next-state: shift window, advance raster counters, flag in-image windows
  always_comb begin
    win_d     = win_q;
    col_d     = col_q;
    row_d     = row_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (en) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_d[(i*5+j)*BIT_WIDTH +: BIT_WIDTH] = win_q[(i*5+j+1)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
      // Right column: oldest row at the top, current pixel at the bottom
      win_d[(0*5+4)*BIT_WIDTH +: BIT_WIDTH] = tap3;
      win_d[(1*5+4)*BIT_WIDTH +: BIT_WIDTH] = tap2;
      win_d[(2*5+4)*BIT_WIDTH +: BIT_WIDTH] = tap1;
      win_d[(3*5+4)*BIT_WIDTH +: BIT_WIDTH] = tap0;
      win_d[(4*5+4)*BIT_WIDTH +: BIT_WIDTH] = px_in;

      if (last_col_s) begin
        col_d = {CW{1'b0}};
        if (last_row_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
        row_d = row_q;
      end

      valid_d = (row_q >= RW'(3'd4)) && (col_q >= CW'(3'd4));
      done_d  = last_col_s && last_row_s;
      if (valid_d) begin
        out_row_d = row_q - RW'(3'd4);
        out_col_d = col_q - CW'(3'd4);
      end else begin
        out_row_d = out_row_q;
        out_col_d = out_col_q;
      end
    end else begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over en
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= {(25*BIT_WIDTH){1'b0}};
      col_q     <= {CW{1'b0}};
      row_q     <= {RW{1'b0}};
      out_row_q <= {RW{1'b0}};
      out_col_q <= {CW{1'b0}};
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      win_q     <= win_d;
      col_q     <= col_d;
      row_q     <= row_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign win        = win_q;
  assign win_valid  = valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv_window5x5.sv
// Self-checking bench for conv_window5x5: a frame-level image model supplies
// pixels/taps and predicts each window from the last five accepted columns.
module tb_conv_window5x5;

  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int BW   = 8;
  localparam int NVALID = (ROWS - 4) * (COLS - 4);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic [BW-1:0]       px_in = '0, tap0 = '0, tap1 = '0, tap2 = '0, tap3 = '0;
  logic [25*BW-1:0]    win;
  logic                win_valid;
  logic [4:0]          out_row;
  logic [4:0]          out_col;
  logic                frame_done;

  conv_window5x5 #(.COLS(COLS), .ROWS(ROWS), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .px_in(px_in),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
    .win(win), .win_valid(win_valid), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] img [ROWS][COLS];
  logic [BW-1:0] hist [5][5];   // hist[j][i]: window column j, row i
  int r_m = 0, c_m = 0, acc_r = -1, acc_c = -1;
  int valid_cnt = 0, done_cnt = 0;

  task automatic model_reset();
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 5; i++) hist[j][i] = '0;
    r_m = 0; c_m = 0; acc_r = -1; acc_c = -1;
  endtask

  task automatic fill_img(input bit ramp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = ramp ? BW'((r * 32 + c) % 256) : BW'($urandom);
  endtask

  // One clock of stimulus with full comparison of every output against the model
  task automatic stream_cycle(input bit en_v);
    logic [BW-1:0]    col [5];
    logic [25*BW-1:0] exp_win;
    logic             exp_valid, exp_done;
    logic [4:0]       exp_or, exp_oc;
    for (int i = 0; i < 5; i++) col[i] = BW'($urandom);
    if (en_v) begin
      col[4] = img[r_m][c_m];
      for (int k = 0; k < 4; k++)
        if (r_m - 1 - k >= 0) col[3-k] = img[r_m-1-k][c_m];
    end
    en = en_v; px_in = col[4]; tap0 = col[3]; tap1 = col[2]; tap2 = col[1]; tap3 = col[0];
    @(posedge clk); #1;
    exp_valid = 1'b0; exp_done = 1'b0; exp_or = '0; exp_oc = '0;
    if (en_v) begin
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 5; i++) hist[j][i] = hist[j+1][i];
      for (int i = 0; i < 5; i++) hist[4][i] = col[i];
      exp_valid = (r_m >= 4) && (c_m >= 4);
      exp_done  = (r_m == ROWS - 1) && (c_m == COLS - 1);
      exp_or = 5'(r_m - 4); exp_oc = 5'(c_m - 4);
      acc_r = r_m; acc_c = c_m;
      if (c_m == COLS - 1) begin
        c_m = 0;
        r_m = (r_m == ROWS - 1) ? 0 : r_m + 1;
      end else begin
        c_m = c_m + 1;
      end
    end
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) exp_win[(i*5+j)*BW +: BW] = hist[j][i];
    checks++;
    if (win !== exp_win) begin
      failures++;
      $display("FAIL win after pixel (%0d,%0d) en=%0d: got %h expected %h", acc_r, acc_c, en_v, win, exp_win);
    end
    checks++;
    if (win_valid !== exp_valid) begin
      failures++;
      $display("FAIL win_valid after pixel (%0d,%0d) en=%0d: got %b expected %b", acc_r, acc_c, en_v, win_valid, exp_valid);
    end
    checks++;
    if (frame_done !== exp_done) begin
      failures++;
      $display("FAIL frame_done after pixel (%0d,%0d) en=%0d: got %b expected %b", acc_r, acc_c, en_v, frame_done, exp_done);
    end
    if (exp_valid) begin
      checks++;
      if (out_row !== exp_or || out_col !== exp_oc) begin
        failures++;
        $display("FAIL coords after pixel (%0d,%0d): got (%0d,%0d) expected (%0d,%0d)", acc_r, acc_c, out_row, out_col, exp_or, exp_oc);
      end
    end
    if (win_valid === 1'b1) valid_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  endtask

  // Drive one whole frame from the current img, with roughly gap_pct% idle cycles
  task automatic run_frame(input int gap_pct);
    int v0 = valid_cnt, d0 = done_cnt, acc = 0, guard = 0;
    bit en_v;
    while (acc < ROWS * COLS && guard < 20 * ROWS * COLS) begin
      en_v = (gap_pct == 0) || (int'($urandom_range(99)) >= gap_pct);
      stream_cycle(en_v);
      if (en_v) acc++;
      guard++;
    end
    checks++;
    if (acc != ROWS * COLS) begin
      failures++;
      $display("FAIL frame_length: accepted %0d pixels, required %0d", acc, ROWS * COLS);
    end
    checks++;
    if (valid_cnt - v0 != NVALID) begin
      failures++;
      $display("FAIL valid_count: got %0d required %0d", valid_cnt - v0, NVALID);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; px_in = BW'($urandom); tap0 = BW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (win !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0) begin
      failures++;
      $display("FAIL reset_state: win=%h valid=%b done=%b row=%0d col=%0d, required all zero", win, win_valid, frame_done, out_row, out_col);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp_frame();
    int v0 = valid_cnt, d0 = done_cnt;
    logic [BW-1:0] e00, e04, e40, e44;
    fill_img(1'b1);
    for (int p = 0; p < ROWS * COLS; p++) begin
      stream_cycle(1'b1);
      if (acc_r == 4 && acc_c == 4) begin
        e00 = win[(0*5+0)*BW +: BW]; e04 = win[(0*5+4)*BW +: BW];
        e40 = win[(4*5+0)*BW +: BW]; e44 = win[(4*5+4)*BW +: BW];
        checks++;
        if (win_valid !== 1'b1 || out_row !== 5'd0 || out_col !== 5'd0) begin
          failures++;
          $display("FAIL first_valid: valid=%b row=%0d col=%0d, required 1,0,0", win_valid, out_row, out_col);
        end
        checks++;
        if (e00 !== 8'd0 || e04 !== 8'd4 || e40 !== 8'd128 || e44 !== 8'd132) begin
          failures++;
          $display("FAIL first_window_corners: got %0d,%0d,%0d,%0d required 0,4,128,132", e00, e04, e40, e44);
        end
      end
      if (acc_r == 5 && acc_c == 4) begin
        e00 = win[(0*5+0)*BW +: BW];
        checks++;
        if (e00 !== 8'd32) begin
          failures++;
          $display("FAIL row_wrap: win(0,0)=%0d required 32", e00);
        end
      end
    end
    checks++;
    if (valid_cnt - v0 != NVALID || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL ramp_counts: valids=%0d dones=%0d required %0d and 1", valid_cnt - v0, done_cnt - d0, NVALID);
    end
  endtask

  task automatic test_gaps();
    fill_img(1'b1);
    run_frame(30);
    fill_img(1'b0);
    run_frame(30);
  endtask

  task automatic test_midframe_reset();
    int guard = 0;
    fill_img(1'b1);
    while (!(acc_r == 10 && acc_c == 17) && guard < ROWS * COLS) begin
      stream_cycle(1'b1);
      guard++;
    end
    rst = 1'b1; en = 1'b1; px_in = BW'($urandom); tap0 = BW'($urandom);
    @(posedge clk); #1;
    checks++;
    if (win !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0 || out_row !== 5'd0 || out_col !== 5'd0) begin
      failures++;
      $display("FAIL midframe_reset: win=%h valid=%b done=%b row=%0d col=%0d, required all zero", win, win_valid, frame_done, out_row, out_col);
    end
    rst = 1'b0;
    model_reset();
    run_frame(0);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    fill_img(1'b0);
    run_frame(0);
    fill_img(1'b0);
    run_frame(0);
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL back_to_back_done: got %0d pulses required 2", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_gaps();
    test_midframe_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
